// File: rtl/alarm_controller.sv
// Alarm sequencer: holds the programmed mm:ss alarm, detects the match edge against
// the running time and walks OFF/ARMED/RINGING/SNOOZED with snooze and auto-silence.
module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int SNOOZE_MAX  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       play_sound,
  output logic [5:0] alm_min,
  output logic [5:0] alm_sec,
  output logic       show_alarm,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt
);

  typedef enum logic [1:0] {
    S_OFF     = 2'b00,
    S_ARMED   = 2'b01,
    S_RINGING = 2'b10,
    S_SNOOZED = 2'b11
  } state_t;

  localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] SNZ_MAX     = 2'(SNOOZE_MAX);

  state_t     state_q, state_d;
  logic [8:0] timer_q, timer_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] alm_min_q, alm_min_d;
  logic [5:0] alm_sec_q, alm_sec_d;
  logic       match, match_q, trigger, edit_ok;

  function automatic logic [5:0] inc_wrap59(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  assign match   = (cur_min == alm_min_q) && (cur_sec == alm_sec_q);
  // Rising edge of the match only, so a stop inside the matching second cannot re-ring
  assign trigger = match && !match_q && !set_mode;
  assign edit_ok = set_mode && !state_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_OFF;
      timer_q   <= '0;
      cnt_q     <= '0;
      alm_min_q <= '0;
      alm_sec_q <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      alm_min_q <= alm_min_d;
      alm_sec_q <= alm_sec_d;
      match_q   <= match;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    alm_min_d = alm_min_q;
    alm_sec_d = alm_sec_q;

    if (edit_ok) begin
      if (inc_min) alm_min_d = inc_wrap59(alm_min_q);
      if (inc_sec) alm_sec_d = inc_wrap59(alm_sec_q);
    end

    case (state_q)
      S_OFF: begin
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!arm) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (trigger) begin
          state_d = S_RINGING;
          cnt_d   = '0;
        end
      end
      S_RINGING: begin
        if (!arm) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (stop) begin
          state_d = S_ARMED;
        end else if (snooze && (cnt_q < SNZ_MAX)) begin
          state_d = S_SNOOZED;
          cnt_d   = cnt_q + 2'd1;
        end else if (tick) begin
          if (timer_q == RING_LAST) state_d = S_ARMED;
          else                      timer_d = timer_q + 9'd1;
        end
      end
      S_SNOOZED: begin
        if (!arm) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (stop) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end else if (tick) begin
          if (timer_q == SNOOZE_LAST) state_d = S_RINGING;
          else                        timer_d = timer_q + 9'd1;
        end
      end
      default: state_d = S_OFF;
    endcase

    // Every state change restarts the tick count
    if (state_d != state_q) timer_d = '0;
  end

  assign play_sound = (state_q == S_RINGING);
  assign show_alarm = edit_ok;
  assign state      = state_q;
  assign snooze_cnt = cnt_q;
  assign alm_min    = alm_min_q;
  assign alm_sec    = alm_sec_q;

endmodule
